// File: rtl/gpio_in_cond_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
package gpio_in_cond_pkg;

  localparam int unsigned DEF_PRESCALE       = 4;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Register width for a value range of n, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

  localparam int unsigned CNT_W = width_of(DEF_DEBOUNCE_TICKS + 1);
  localparam int unsigned PRE_W = width_of(DEF_PRESCALE);

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

endpackage

// File: rtl/gpio_in_conditioner_bit.sv
// One conditioned input bit: 2-flop synchroniser, tick-based debounce, optional edge pulses.
// Edge pulse flops exist only when GPIO_IN_COND_EDGE_EN is defined.
module gpio_debounce_bit
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned CNT_W_P        = CNT_W,
  parameter logic        RESET_BIT      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic filt_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam bit FiltBuilt = (DEBOUNCE_TICKS != 0);
  localparam logic [CNT_W_P-1:0] CntLast =
      CNT_W_P'((DEBOUNCE_TICKS == 0) ? 0 : DEBOUNCE_TICKS - 1);

  logic               sync1_q, sync2_q;
  logic               clean_q, clean_d;
  logic               state_q, state_d;
  logic [CNT_W_P-1:0] cnt_q, cnt_d;

  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!(filt_i && FiltBuilt)) begin
      clean_d = sync2_q;
      cnt_d   = '0;
      state_d = ST_STABLE;
    end else if (sync2_q == clean_q) begin
      cnt_d   = '0;
      state_d = ST_STABLE;
    end else begin
      state_d = ST_PENDING;
      if (tick_i) begin
        if (cnt_q == CntLast) begin
          clean_d = sync2_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          // cnt is 0 whenever STABLE, so the first tick always lands on 1
          cnt_d = (state_q == ST_PENDING) ? cnt_q + 1'b1 : CNT_W_P'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= RESET_BIT;
      sync2_q <= RESET_BIT;
      clean_q <= RESET_BIT;
      cnt_q   <= '0;
      state_q <= ST_STABLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign clean_o = clean_q;

`ifdef GPIO_IN_COND_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= ~clean_q & clean_d;
      fall_q <= clean_q & ~clean_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions asynchronous GPIO pads for the GPIO core: shared prescaler plus one debounce slice
// per bit. Define GPIO_IN_COND_EDGE_EN to build the GPIO_RISE/GPIO_FALL pulse registers.
module gpio_in_conditioner
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned       IO_NUM         = 8,
  parameter int unsigned       PRESCALE       = DEF_PRESCALE,
  parameter int unsigned       DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [IO_NUM-1:0] RESET_VAL      = '0,
  parameter logic [IO_NUM-1:0] BYPASS_MASK    = '0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [IO_NUM-1:0] GPIO_RAW,
  input  logic              FILT_EN,
  output logic [IO_NUM-1:0] GPIO_IN_CLEAN,
  output logic [IO_NUM-1:0] GPIO_RISE,
  output logic [IO_NUM-1:0] GPIO_FALL
);

  localparam int unsigned CntW = width_of(DEBOUNCE_TICKS + 1);
  localparam int unsigned PreW = width_of(PRESCALE);
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;

  // Free-running: input activity never re-phases the debounce tick.
  assign tick = (pre_q == PreLast);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .CNT_W_P        (CntW),
      .RESET_BIT      (RESET_VAL[i])
    ) u_bit (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .tick_i  (tick),
      .filt_i  (FILT_EN & ~BYPASS_MASK[i]),
      .raw_i   (GPIO_RAW[i]),
      .clean_o (GPIO_IN_CLEAN[i]),
      .rise_o  (GPIO_RISE[i]),
      .fall_o  (GPIO_FALL[i])
    );
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: PRESCALE=4, DEBOUNCE_TICKS=3, RESET_VAL=A5, bypass bit7.
module tb_gpio_in_conditioner;

`ifdef GPIO_IN_COND_EDGE_EN
  localparam logic [7:0] EdgeMask = 8'hFF;
`else
  localparam logic [7:0] EdgeMask = 8'h00;
`endif

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       FILT_EN;
  logic [7:0] GPIO_RAW;
  logic [7:0] GPIO_IN_CLEAN;
  logic [7:0] GPIO_RISE;
  logic [7:0] GPIO_FALL;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int edge_err = 0;

  logic       armed = 1'b0;
  logic       rst_seen;
  logic [7:0] prev_clean;

  gpio_in_conditioner #(
    .IO_NUM         (8),
    .PRESCALE       (4),
    .DEBOUNCE_TICKS (3),
    .RESET_VAL      (8'hA5),
    .BYPASS_MASK    (8'h80)
  ) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .GPIO_RAW      (GPIO_RAW),
    .FILT_EN       (FILT_EN),
    .GPIO_IN_CLEAN (GPIO_IN_CLEAN),
    .GPIO_RISE     (GPIO_RISE),
    .GPIO_FALL     (GPIO_FALL)
  );

  initial forever #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic expect_out(input string tag, input logic [7:0] clean, input logic [7:0] rise,
                            input logic [7:0] fall);
    check_eq({tag, "_clean"}, {24'h0, GPIO_IN_CLEAN}, {24'h0, clean});
    check_eq({tag, "_rise"}, {24'h0, GPIO_RISE}, {24'h0, rise & EdgeMask});
    check_eq({tag, "_fall"}, {24'h0, GPIO_FALL}, {24'h0, fall & EdgeMask});
  endtask

  // Every visible clean change must coincide with exactly one matching pulse, and nothing else.
  always @(posedge PCLK) rst_seen <= PRESET;

  always @(negedge PCLK) begin
    if (armed && rst_seen === 1'b0) begin
      if (GPIO_RISE !== ((~prev_clean & GPIO_IN_CLEAN) & EdgeMask) ||
          GPIO_FALL !== ((prev_clean & ~GPIO_IN_CLEAN) & EdgeMask)) begin
        edge_err++;
      end
    end
    prev_clean = GPIO_IN_CLEAN;
  end

  initial begin
    PRESET   = 1'b1;
    FILT_EN  = 1'b1;
    GPIO_RAW = 8'h00;
    repeat (3) step();
    expect_out("s1_reset", 8'hA5, 8'h00, 8'h00);
    armed  = 1'b1;
    PRESET = 1'b0;
    cyc    = 0;

    // Scenario 1: reset value bits fall; bypassed bit7 after 3 edges, filtered at first 3rd tick.
    run_to(2);
    check_eq("s1_hold", {24'h0, GPIO_IN_CLEAN}, 32'hA5);
    run_to(3);
    expect_out("s1_bit7", 8'h25, 8'h00, 8'h80);
    run_to(4);
    check_eq("s1_fall7_once", {24'h0, GPIO_FALL}, 32'h0);
    run_to(11);
    check_eq("s1_prefilt", {24'h0, GPIO_IN_CLEAN}, 32'h25);
    run_to(12);
    expect_out("s1_filt", 8'h00, 8'h00, 8'h25);
    run_to(13);
    check_eq("s1_fall_once", {24'h0, GPIO_FALL}, 32'h0);

    // Scenario 2: bit0 0->1 steady; change lands on the minimum-latency edge (11 edges).
    GPIO_RAW = 8'h01;
    run_to(23);
    check_eq("s2_early", {24'h0, GPIO_IN_CLEAN}, 32'h00);
    run_to(24);
    expect_out("s2_rise", 8'h01, 8'h01, 8'h00);
    run_to(25);
    check_eq("s2_rise_once", {24'h0, GPIO_RISE}, 32'h0);

    // Scenario 3: bit1 bounces every 5 cycles; never more than 2 ticks of agreement.
    for (int k = 0; k < 8; k++) begin
      GPIO_RAW[1] = (k % 2 == 0);
      run_to(25 + 5 * (k + 1));
      check_eq("s3_bounce", {24'h0, GPIO_IN_CLEAN}, 32'h01);
    end
    GPIO_RAW[1] = 1'b1;
    run_to(75);
    check_eq("s3_early", {24'h0, GPIO_IN_CLEAN}, 32'h01);
    run_to(76);
    expect_out("s3_rise", 8'h03, 8'h02, 8'h00);
    run_to(77);
    check_eq("s3_rise_once", {24'h0, GPIO_RISE}, 32'h0);

    // Scenario 4: 1-cycle pulse on bypassed bit7 and filtered bit6.
    GPIO_RAW = 8'hC3;
    step();
    GPIO_RAW = 8'h03;
    run_to(79);
    check_eq("s4_lat", {24'h0, GPIO_IN_CLEAN}, 32'h03);
    run_to(80);
    expect_out("s4_high", 8'h83, 8'h80, 8'h00);
    run_to(81);
    expect_out("s4_low", 8'h03, 8'h00, 8'h80);
    run_to(84);
    check_eq("s4_bit6_filtered", {24'h0, GPIO_IN_CLEAN}, 32'h03);

    // Scenario 5: bit2 pending with cnt=2 when FILT_EN drops.
    GPIO_RAW = 8'h07;
    run_to(92);
    check_eq("s5_pending", {24'h0, GPIO_IN_CLEAN}, 32'h03);
    FILT_EN = 1'b0;
    run_to(93);
    expect_out("s5_unfilt", 8'h07, 8'h04, 8'h00);
    run_to(94);
    FILT_EN = 1'b1;
    run_to(96);
    expect_out("s5_reenable", 8'h07, 8'h00, 8'h00);
    GPIO_RAW = 8'h03;
    run_to(107);
    check_eq("s5_refilt_early", {24'h0, GPIO_IN_CLEAN}, 32'h07);
    run_to(108);
    expect_out("s5_refilt", 8'h03, 8'h00, 8'h04);

    // Scenario 6: reset while bit3 pending discards its count and the prescaler phase.
    run_to(110);
    GPIO_RAW = 8'h0B;
    run_to(117);
    check_eq("s6_pending", {24'h0, GPIO_IN_CLEAN}, 32'h03);
    PRESET = 1'b1;
    run_to(118);
    expect_out("s6_reset", 8'hA5, 8'h00, 8'h00);
    PRESET = 1'b0;
    run_to(121);
    expect_out("s6_bit7", 8'h25, 8'h00, 8'h80);
    run_to(129);
    check_eq("s6_early", {24'h0, GPIO_IN_CLEAN}, 32'h25);
    run_to(130);
    expect_out("s6_accept", 8'h0B, 8'h0A, 8'h24);
    run_to(131);
    expect_out("s6_after", 8'h0B, 8'h00, 8'h00);

    step();
    check_eq("edge_monitor", edge_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
